// File: rtl/integral_image_cache_reader.sv
// rtl/integral_image_cache_reader.sv - raster-order dump of the integral image cache onto a word stream
// Credit-gated read issue, latency-matching valid pipe, show-ahead output FIFO.
module integral_image_cache_reader #(
    parameter int ADDR_WIDTH   = 5,
    parameter int WORD_SIZE    = 32,
    parameter int ROW_WIDTH    = 25,
    parameter int COL_WIDTH    = 25,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  re,
    output logic [ADDR_WIDTH-1:0] raddrX,
    output logic [ADDR_WIDTH-1:0] raddrY,
    input  logic [WORD_SIZE-1:0]  rdata,
    output logic [WORD_SIZE-1:0]  data,
    output logic                  data_ready,
    input  logic                  data_wanted
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic [CW-1:0]           outst_q, outst_d, cnt_q, cnt_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
    logic [WORD_SIZE-1:0]    mem_q [FIFO_DEPTH];
    logic [WORD_SIZE-1:0]    mem_d [FIFO_DEPTH];
    logic                    done_q, done_d;

    logic          issue, push, pop, x_last, y_last;
    logic [CW:0]   credit_used;

    always_comb begin
        push        = vld_q[READ_LATENCY-1];
        pop         = (cnt_q != '0) && data_wanted;
        x_last      = (x_q == ADDR_WIDTH'(ROW_WIDTH - 1));
        y_last      = (y_q == ADDR_WIDTH'(COL_WIDTH - 1));
        // Credit ignores a same-cycle pop so the FIFO can never be oversubscribed.
        credit_used = (CW+1)'(outst_q) + (CW+1)'(cnt_q);
        issue       = (state_q == SCAN) && (credit_used < (CW+1)'(FIFO_DEPTH));

        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        wr_d    = wr_q;
        rd_d    = rd_q;
        mem_d   = mem_q;
        outst_d = outst_q + CW'(issue) - CW'(push);
        cnt_d   = cnt_q + CW'(push) - CW'(pop);

        vld_d[0] = issue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end

        if (push) begin
            mem_d[wr_q] = rdata;
            wr_d        = (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    x_d     = '0;
                    y_d     = '0;
                    outst_d = '0;
                    cnt_d   = '0;
                    wr_d    = '0;
                    rd_d    = '0;
                    vld_d   = '0;
                end
            end
            SCAN: begin
                if (issue) begin
                    if (x_last) begin
                        x_d = '0;
                        if (y_last) begin
                            y_d     = '0;
                            state_d = DRAIN;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if ((outst_q == '0) && ((cnt_q == '0) || ((cnt_q == CW'(1)) && pop))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            outst_q <= '0;
            cnt_q   <= '0;
            vld_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            outst_q <= outst_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign re         = issue;
    assign raddrX     = x_q;
    assign raddrY     = y_q;
    assign data       = mem_q[rd_q];
    assign data_ready = (cnt_q != '0);

    fifo_overflow_chk: assert property (@(posedge clk) disable iff (!resetn)
        !(push && !pop && (cnt_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_integral_image_cache_reader.sv
// tb/tb_integral_image_cache_reader.sv - directed table-driven bench for integral_image_cache_reader
module tb_integral_image_cache_reader;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Default-parameter instance
    logic        start_a, busy_a, done_a, re_a, data_ready_a, data_wanted_a;
    logic [4:0]  raddrX_a, raddrY_a;
    logic [31:0] rdata_a, data_a;
    logic [31:0] pipe_a [2];

    integral_image_cache_reader dut_a (
        .clk(clk), .resetn(resetn), .start(start_a), .busy(busy_a), .done(done_a),
        .re(re_a), .raddrX(raddrX_a), .raddrY(raddrY_a), .rdata(rdata_a),
        .data(data_a), .data_ready(data_ready_a), .data_wanted(data_wanted_a)
    );

    always @(posedge clk) begin
        pipe_a[0] <= re_a ? {22'b0, raddrY_a, raddrX_a} : 32'hDEADBEEF;
        pipe_a[1] <= pipe_a[0];
    end
    assign rdata_a = pipe_a[1];

    // Small instance: latency 1, 3-entry FIFO, 2x2 cache
    logic        start_b, busy_b, done_b, re_b, data_ready_b, data_wanted_b;
    logic [4:0]  raddrX_b, raddrY_b;
    logic [31:0] rdata_b, data_b;

    integral_image_cache_reader #(
        .ADDR_WIDTH(5), .WORD_SIZE(32), .ROW_WIDTH(2), .COL_WIDTH(2),
        .READ_LATENCY(1), .FIFO_DEPTH(3)
    ) dut_b (
        .clk(clk), .resetn(resetn), .start(start_b), .busy(busy_b), .done(done_b),
        .re(re_b), .raddrX(raddrX_b), .raddrY(raddrY_b), .rdata(rdata_b),
        .data(data_b), .data_ready(data_ready_b), .data_wanted(data_wanted_b)
    );

    always @(posedge clk) rdata_b <= re_b ? {22'b0, raddrY_b, raddrX_b} : 32'hDEADBEEF;

    function automatic logic [31:0] word_of(input int k);
        return 32'(((k / 25) << 5) | (k % 25));
    endfunction

    function automatic logic want_for(input int mode, input int n);
        if (mode == 1) return 1'($urandom_range(0, 1));
        if (mode == 2) return (n >= 40);
        return 1'b1;
    endfunction

    typedef struct {
        int    mode;        // 0 always ready, 1 random ready, 2 ready held low until cycle 40
        int    restart_at;  // cycle of a second start pulse, -1 none
        int    reset_at;    // cycle to pull resetn low, -1 none
        int    exp_done;    // expected done cycle, 0 = only require that done occurs
        string tag;
    } vec_t;

    task automatic run_dump(input vec_t v);
        int n = 0, taken = 0, issued = 0, first = -1, done_at = -1;
        int bad_order = 0, bad_stable = 0, bad_credit = 0;
        logic prev_hold = 1'b0;
        logic [31:0] prev_data = '0;

        @(posedge clk); #1;
        start_a = 1'b1;
        data_wanted_a = want_for(v.mode, 0);
        while (n < 3000) begin
            @(negedge clk);
            if (n == 1) begin
                check({v.tag, "_c1_busy"}, busy_a, 1);
                check({v.tag, "_c1_re"}, re_a, 1);
                check({v.tag, "_c1_addr"}, {raddrY_a, raddrX_a}, 0);
            end
            if (data_ready_a && first < 0) first = n;
            if (prev_hold && (!data_ready_a || data_a !== prev_data)) bad_stable++;
            if (re_a) begin
                if (issued - taken >= 4) bad_credit++;
                issued++;
            end
            if (data_ready_a && data_wanted_a) begin
                if (data_a !== word_of(taken)) bad_order++;
                taken++;
            end
            prev_hold = data_ready_a && !data_wanted_a;
            prev_data = data_a;
            if (v.mode == 2 && n == 39) begin
                check({v.tag, "_held_reads"}, issued, 4);
                check({v.tag, "_held_ready"}, data_ready_a, 1);
                check({v.tag, "_held_data"}, data_a, 0);
            end
            if (done_at >= 0) begin
                check({v.tag, "_done_width"}, done_a, 0);
                break;
            end
            if (done_a) begin
                done_at = n;
                check({v.tag, "_busy_at_done"}, busy_a, 0);
            end
            @(posedge clk); #1;
            n++;
            start_a = (n == v.restart_at);
            data_wanted_a = want_for(v.mode, n);
            if (n == v.reset_at) begin
                resetn = 1'b0;
                #1;
                check({v.tag, "_rst_busy"}, busy_a, 0);
                check({v.tag, "_rst_done"}, done_a, 0);
                check({v.tag, "_rst_re"}, re_a, 0);
                check({v.tag, "_rst_addr"}, {raddrY_a, raddrX_a}, 0);
                check({v.tag, "_rst_data"}, data_a, 0);
                check({v.tag, "_rst_ready"}, data_ready_a, 0);
                @(negedge clk);
                resetn = 1'b1;
                start_a = 1'b0;
                data_wanted_a = 1'b1;
                repeat (3) @(posedge clk);
                return;
            end
        end
        start_a = 1'b0;
        data_wanted_a = 1'b1;
        check({v.tag, "_first_ready"}, first, 4);
        if (v.exp_done > 0) check({v.tag, "_done_cycle"}, done_at, v.exp_done);
        else check({v.tag, "_done_seen"}, done_at >= 0, 1);
        check({v.tag, "_word_count"}, taken, 625);
        check({v.tag, "_order_errs"}, bad_order, 0);
        check({v.tag, "_stable_errs"}, bad_stable, 0);
        check({v.tag, "_credit_errs"}, bad_credit, 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic run_small();
        logic [31:0] exp_b [4];
        int n = 0, taken = 0, first = -1, done_at = -1, bad = 0;
        exp_b[0] = 32'd0;  exp_b[1] = 32'd1;
        exp_b[2] = 32'd32; exp_b[3] = 32'd33;
        @(posedge clk); #1;
        start_b = 1'b1;
        while (n < 100 && done_at < 0) begin
            @(negedge clk);
            if (data_ready_b && first < 0) first = n;
            if (data_ready_b && data_wanted_b) begin
                if (taken > 3 || data_b !== exp_b[taken]) bad++;
                taken++;
            end
            if (done_b) done_at = n;
            @(posedge clk); #1;
            start_b = 1'b0;
            n++;
        end
        check("small_first_ready", first, 3);
        check("small_done_cycle", done_at, 7);
        check("small_word_count", taken, 4);
        check("small_order_errs", bad, 0);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{0, -1, -1, 629, "nobp"};
        vecs[1] = '{1, -1, -1, 0,   "rand"};
        vecs[2] = '{2, -1, -1, 665, "hold"};
        vecs[3] = '{0, 100, -1, 629, "restart"};
        vecs[4] = '{0, -1, 50, 0,   "reset"};
        vecs[5] = '{0, -1, -1, 629, "after_reset"};

        start_a = 1'b0; data_wanted_a = 1'b1;
        start_b = 1'b0; data_wanted_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_re", re_a, 0);
        check("reset_addr", {raddrY_a, raddrX_a}, 0);
        check("reset_data", data_a, 0);
        check("reset_ready", data_ready_a, 0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) run_dump(vecs[i]);
        run_small();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
